mem_arbiter: RTL and testbench

Arbitrates the core's single external memory bus between the instruction-fetch requester and the load/store (data) requester of the pipelined datapath.
- Sequences each access as one bus transaction with a request/acknowledge handshake.
- Performs byte-lane steering and load sign/zero extension from funct3.
- Drives a stall to the hazard logic while the pipeline waits.
- Sits between the datapath memory ports and the SoC memory/wishbone-style bus.

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store.
// Steers byte lanes and extends loads. Define MEM_ARB_RR_EN to get round-robin grants.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [DATA_WIDTH-1:0] i_if_addr,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    output logic                  o_if_ready,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [DATA_WIDTH-1:0] i_dm_addr,
    input  logic [DATA_WIDTH-1:0] i_dm_wdata,
    input  logic [2:0]            i_dm_funct3,
    output logic [DATA_WIDTH-1:0] o_dm_rdata,
    output logic                  o_dm_ready,
    output logic                  o_dm_misalign,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [DATA_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    output logic [3:0]            o_bus_be,
    input  logic                  i_bus_ack,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_stall
);

    typedef enum logic [1:0] {IDLE, IF_BUS, DM_BUS, DM_ERR} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lane_q, lane_d;
    logic                  if_ready_q, if_ready_d;
    logic                  dm_ready_q, dm_ready_d;
    logic                  misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

    logic                  grant_dm;
    logic                  dm_misalign;
    logic [3:0]            dm_be;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic                  ld_sgn;
    logic                  unused_if_addr;

    assign unused_if_addr = ^i_if_addr[1:0];

`ifdef MEM_ARB_RR_EN
    // 1 = data was granted last; the other requester wins a tie.
    logic last_dm_q, last_dm_d;
    assign grant_dm = i_dm_req & (~i_if_req | ~last_dm_q);
`else
    assign grant_dm = i_dm_req;
`endif

    always_comb begin
        dm_misalign = 1'b0;
        dm_be       = 4'hF;
        dm_wdata    = i_dm_wdata;
        case (i_dm_funct3[1:0])
            2'b00: begin
                dm_be    = 4'b0001 << i_dm_addr[1:0];
                dm_wdata = {4{i_dm_wdata[7:0]}};
            end
            2'b01: begin
                dm_misalign = i_dm_addr[0];
                dm_be       = 4'b0011 << {i_dm_addr[1], 1'b0};
                dm_wdata    = {2{i_dm_wdata[15:0]}};
            end
            2'b10: dm_misalign = |i_dm_addr[1:0];
            default: ;
        endcase
    end

    // Load path uses the lane/size captured at request time, not the live inputs.
    assign rd_shift = i_bus_rdata >> {lane_q, 3'b000};
    assign ld_sgn   = ~f3_q[2];

    always_comb begin
        case (f3_q[1:0])
            2'b00:   ld_ext = {{(DATA_WIDTH-8){ld_sgn & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_ext = {{(DATA_WIDTH-16){ld_sgn & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_ext = i_bus_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        f3_d       = f3_q;
        lane_d     = lane_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        misalign_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_dm_d  = last_dm_q;
`endif
        case (state_q)
            IDLE: begin
                // The requester just answered still holds req this cycle; skip it.
                if (!if_ready_q && !dm_ready_q) begin
                    if (grant_dm) begin
`ifdef MEM_ARB_RR_EN
                        last_dm_d = 1'b1;
`endif
                        if (dm_misalign) begin
                            state_d = DM_ERR;
                        end else begin
                            state_d = DM_BUS;
                            addr_d  = {i_dm_addr[DATA_WIDTH-1:2], 2'b00};
                            we_d    = i_dm_we;
                            be_d    = dm_be;
                            wdata_d = dm_wdata;
                            f3_d    = i_dm_funct3;
                            lane_d  = i_dm_addr[1:0];
                        end
                    end else if (i_if_req) begin
`ifdef MEM_ARB_RR_EN
                        last_dm_d = 1'b0;
`endif
                        state_d = IF_BUS;
                        addr_d  = {i_if_addr[DATA_WIDTH-1:2], 2'b00};
                        we_d    = 1'b0;
                        be_d    = 4'hF;
                    end
                end
            end
            IF_BUS: begin
                if (i_bus_ack) begin
                    state_d    = IDLE;
                    if_ready_d = 1'b1;
                    if_rdata_d = i_bus_rdata;
                end
            end
            DM_BUS: begin
                if (i_bus_ack) begin
                    state_d    = IDLE;
                    dm_ready_d = 1'b1;
                    dm_rdata_d = ld_ext;
                end
            end
            DM_ERR: begin
                state_d    = IDLE;
                dm_ready_d = 1'b1;
                misalign_d = 1'b1;
                dm_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            lane_q     <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            misalign_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_dm_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            lane_q     <= lane_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            misalign_q <= misalign_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_dm_q  <= last_dm_d;
`endif
        end
    end

    assign o_bus_req     = (state_q == IF_BUS) || (state_q == DM_BUS);
    assign o_bus_we      = we_q;
    assign o_bus_addr    = addr_q;
    assign o_bus_wdata   = wdata_q;
    assign o_bus_be      = be_q;
    assign o_if_ready    = if_ready_q;
    assign o_if_rdata    = if_rdata_q;
    assign o_dm_ready    = dm_ready_q;
    assign o_dm_rdata    = dm_rdata_q;
    assign o_dm_misalign = misalign_q;
    assign o_stall       = (i_if_req & ~if_ready_q) | (i_dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small bus responder plus hand-computed expectations.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req, i_dm_req, i_dm_we, i_bus_ack;
    logic [31:0] i_if_addr, i_dm_addr, i_dm_wdata, i_bus_rdata;
    logic [2:0]  i_dm_funct3;
    logic [31:0] o_if_rdata, o_dm_rdata, o_bus_addr, o_bus_wdata;
    logic        o_if_ready, o_dm_ready, o_dm_misalign, o_bus_req, o_bus_we, o_stall;
    logic [3:0]  o_bus_be;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .i_dm_funct3(i_dm_funct3), .o_dm_rdata(o_dm_rdata), .o_dm_ready(o_dm_ready),
        .o_dm_misalign(o_dm_misalign), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_stall(o_stall)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus responder: captures fields on the first cycle of a transaction, acks after ack_dly cycles.
    logic        resp_en = 1'b0;
    int          ack_dly = 0;
    int          cnt = 0;
    int          bus_cnt = 0;
    logic        in_txn = 1'b0;
    logic [31:0] bus_word = '0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always @(negedge clk) begin
        if (i_bus_ack) begin
            i_bus_ack = 1'b0;
            in_txn    = 1'b0;
        end else if (resp_en && o_bus_req) begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                cnt       = 0;
                cap_addr  = o_bus_addr;
                cap_wdata = o_bus_wdata;
                cap_be    = o_bus_be;
                cap_we    = o_bus_we;
                bus_cnt++;
            end
            if (cnt == ack_dly) begin
                i_bus_ack   = 1'b1;
                i_bus_rdata = bus_word;
            end else begin
                cnt++;
            end
        end
    end

    task automatic dm_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic mis,
                         output int cyc);
        logic done;
        @(negedge clk);
        i_dm_req = 1'b1; i_dm_we = we; i_dm_addr = addr; i_dm_wdata = wdata; i_dm_funct3 = f3;
        cyc = 0; rd = '0; mis = 1'b0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("dm_stall", {31'b0, o_stall}, 32'd1);
            if (o_dm_ready) begin
                done = 1'b1; rd = o_dm_rdata; mis = o_dm_misalign;
            end
        end
        i_dm_req = 1'b0;
        if (!done) chk("dm_timeout", 32'd0, 32'd1);
    endtask

    task automatic if_op(input logic [31:0] addr, output logic [31:0] rd, output int cyc);
        logic done;
        @(negedge clk);
        i_if_req = 1'b1; i_if_addr = addr;
        cyc = 0; rd = '0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("if_stall", {31'b0, o_stall}, 32'd1);
            if (o_if_ready) begin
                done = 1'b1; rd = o_if_rdata;
            end
        end
        i_if_req = 1'b0;
        if (!done) chk("if_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] exp;
        string       tag;
    } ld_vec_t;

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          cyc;
        int          first, seen, b0;
        logic        if_done, dm_done;
        ld_vec_t     lv[6];

        rst = 1'b1;
        i_if_req = 0; i_if_addr = 0; i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0;
        i_dm_wdata = 0; i_dm_funct3 = 0; i_bus_ack = 0; i_bus_rdata = 0;
        #12;
        chk("rst_bus_req", {31'b0, o_bus_req}, 32'd0);
        chk("rst_bus_we_be", {27'b0, o_bus_we, o_bus_be}, 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'd0);
        chk("rst_bus_wdata", o_bus_wdata, 32'd0);
        chk("rst_readies", {29'b0, o_if_ready, o_dm_ready, o_dm_misalign}, 32'd0);
        chk("rst_if_rdata", o_if_rdata, 32'd0);
        chk("rst_dm_rdata", o_dm_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;

        // Fetch, ack after 2 wait cycles
        ack_dly = 2; bus_word = 32'h00500093;
        if_op(32'h100, rd, cyc);
        chk("fetch_rdata", rd, 32'h00500093);
        chk("fetch_latency", cyc, 32'd4);
        chk("fetch_bus_addr", cap_addr, 32'h100);
        chk("fetch_bus_be_we", {27'b0, cap_we, cap_be}, 32'h0F);
        #1 chk("fetch_stall_after", {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        chk("fetch_ready_pulse", {31'b0, o_if_ready}, 32'd0);

        // Stores: byte and half lane steering
        ack_dly = 0;
        dm_op(1'b1, 32'h203, 32'h000000AB, 3'b000, rd, mis, cyc);
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_be_we", {27'b0, cap_we, cap_be}, 32'h18);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        chk("sb_latency", cyc, 32'd2);
        dm_op(1'b1, 32'h206, 32'h00001234, 3'b001, rd, mis, cyc);
        chk("sh_addr", cap_addr, 32'h204);
        chk("sh_be", {28'b0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'h12341234);
        @(negedge clk);
        chk("dm_ready_pulse", {31'b0, o_dm_ready}, 32'd0);

        // Loads from word 0x80FF7F01 at 0x300
        bus_word = 32'h80FF7F01;
        lv[0] = '{32'h302, 3'b000, 32'hFFFFFFFF, "lb_302"};
        lv[1] = '{32'h302, 3'b100, 32'h000000FF, "lbu_302"};
        lv[2] = '{32'h302, 3'b001, 32'hFFFF80FF, "lh_302"};
        lv[3] = '{32'h302, 3'b101, 32'h000080FF, "lhu_302"};
        lv[4] = '{32'h301, 3'b000, 32'h0000007F, "lb_301"};
        lv[5] = '{32'h300, 3'b010, 32'h80FF7F01, "lw_300"};
        foreach (lv[i]) begin
            dm_op(1'b0, lv[i].addr, 32'h0, lv[i].f3, rd, mis, cyc);
            chk(lv[i].tag, rd, lv[i].exp);
        end
        chk("lw_bus_addr", cap_addr, 32'h300);
        chk("lw_misalign_low", {31'b0, mis}, 32'd0);

        // Misaligned word load: no bus cycle
        b0 = bus_cnt;
        dm_op(1'b0, 32'h302, 32'h0, 3'b010, rd, mis, cyc);
        chk("mis_flag", {31'b0, mis}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
        chk("mis_latency", cyc, 32'd2);
        chk("mis_no_bus", bus_cnt - b0, 32'd0);

        // Simultaneous fetch and load (last grant was data)
        bus_word = 32'h0000CAFE;
        @(negedge clk);
        i_if_req = 1; i_if_addr = 32'h400;
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h500; i_dm_funct3 = 3'b010;
        first = 0; seen = 0; if_done = 0; dm_done = 0;
        while (!(if_done && dm_done) && seen < 60) begin
            @(negedge clk);
            seen++;
            if (o_dm_ready && !dm_done) begin
                dm_done = 1; i_dm_req = 0;
                if (first == 0) first = 1;
                chk("both_dm_rdata", o_dm_rdata, 32'h0000CAFE);
            end
            if (o_if_ready && !if_done) begin
                if_done = 1; i_if_req = 0;
                if (first == 0) first = 2;
                chk("both_if_rdata", o_if_rdata, 32'h0000CAFE);
            end
        end
        i_if_req = 0; i_dm_req = 0;
`ifdef MEM_ARB_RR_EN
        chk("both_order", first, 32'd2);
`else
        chk("both_order", first, 32'd1);
`endif

        // Reset while a data bus cycle waits for ack
        resp_en = 1'b0;
        @(negedge clk);
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h300; i_dm_funct3 = 3'b010;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_req_before", {31'b0, o_bus_req}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_req_async", {31'b0, o_bus_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0; i_dm_req = 0;
        @(negedge clk);
        #1 i_bus_ack = 1'b1; i_bus_rdata = 32'h12345678;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_dm_ready || o_if_ready || o_bus_req) seen++;
        end
        chk("rst_late_ack_ignored", seen, 32'd0);

        resp_en = 1'b1; ack_dly = 1; bus_word = 32'h00000013;
        if_op(32'h104, rd, cyc);
        chk("post_rst_fetch", rd, 32'h00000013);
        chk("post_rst_latency", cyc, 32'd3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end
endmodule
